// File: rtl/flash_pkg.sv
// Shared constants and types for the NOR flash read controller.
package flash_pkg;

   localparam int          FLASH_AW = 23;
   localparam int          OFFS_W   = 20;
   localparam logic [22:0] PRG_BASE = 23'h000000;
   localparam logic [22:0] CHR_BASE = 23'h400000;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } fctl_state_t;

   typedef enum logic {
      GNT_PRG = 1'b0,
      GNT_CHR = 1'b1
   } fctl_grant_t;

endpackage

// File: rtl/flash_rr_arb2.sv
// Two-way round-robin arbiter: picks PRG or CHR from the eligible pair,
// giving a tie to whichever client was not served last.
module flash_rr_arb2
   import flash_pkg::*;
(
   input  logic        prg_elig,
   input  logic        chr_elig,
   input  fctl_grant_t last_grant,
   output logic        gnt_valid,
   output fctl_grant_t gnt_sel
);

   // Grant decision from eligibility and last served client
   always_comb begin
      gnt_valid = 1'b0;
      gnt_sel   = GNT_PRG;
      if (prg_elig && chr_elig) begin
         gnt_valid = 1'b1;
         if (last_grant == GNT_PRG) begin
            gnt_sel = GNT_CHR;
         end else begin
            gnt_sel = GNT_PRG;
         end
      end else if (prg_elig) begin
         gnt_valid = 1'b1;
         gnt_sel   = GNT_PRG;
      end else if (chr_elig) begin
         gnt_valid = 1'b1;
         gnt_sel   = GNT_CHR;
      end else begin
         gnt_valid = 1'b0;
         gnt_sel   = last_grant;
      end
   end

endmodule

// File: rtl/flash_read_ctrl.sv
// Byte-read controller for the parallel NOR flash. Serves PRG and CHR
// clients round-robin, maps each offset into the client's region, waits a
// fixed access time and returns the sampled byte with a one-cycle ack.
module flash_read_ctrl
   import flash_pkg::*;
#(
   parameter int          WAIT_CYCLES = 3,
   parameter int          FLASH_AW    = flash_pkg::FLASH_AW,
   parameter int          OFFS_W      = flash_pkg::OFFS_W,
   parameter logic [22:0] PRG_BASE    = flash_pkg::PRG_BASE,
   parameter logic [22:0] CHR_BASE    = flash_pkg::CHR_BASE
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_prg_req,
   input  logic [OFFS_W-1:0]   i_prg_addr,
   output logic                o_prg_ack,
   output logic [7:0]          o_prg_data,
   input  logic                i_chr_req,
   input  logic [OFFS_W-1:0]   i_chr_addr,
   output logic                o_chr_ack,
   output logic [7:0]          o_chr_data,
   output logic [FLASH_AW-1:0] o_flash_addr,
   input  logic [7:0]          i_flash_q,
   output logic                o_busy
);

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   fctl_state_t         state_r,      state_s;
   fctl_grant_t         cur_grant_r,  cur_grant_s;
   fctl_grant_t         last_grant_r, last_grant_s;
   logic [3:0]          cnt_r,        cnt_s;
   logic [FLASH_AW-1:0] addr_r,       addr_s;
   logic                busy_r,       busy_s;
   logic                prg_ack_r,    prg_ack_s;
   logic                chr_ack_r,    chr_ack_s;
   logic [7:0]          prg_data_r,   prg_data_s;
   logic [7:0]          chr_data_r,   chr_data_s;

   logic                prg_elig_s;
   logic                chr_elig_s;
   logic                gnt_valid_s;
   fctl_grant_t         gnt_sel_s;
   logic [FLASH_AW-1:0] prg_map_s;
   logic [FLASH_AW-1:0] chr_map_s;

   // A client whose ack is currently high sits out one cycle, so a request
   // still held during its ack cycle is not served twice.
   assign prg_elig_s = i_prg_req && !prg_ack_r;
   assign chr_elig_s = i_chr_req && !chr_ack_r;

   // Region mapping: upper bits come only from the base, so an offset can
   // never reach into the neighbouring region.
   assign prg_map_s = FLASH_AW'(PRG_BASE) | {{(FLASH_AW-OFFS_W){1'b0}}, i_prg_addr};
   assign chr_map_s = FLASH_AW'(CHR_BASE) | {{(FLASH_AW-OFFS_W){1'b0}}, i_chr_addr};

   flash_rr_arb2 u_arb (
      .prg_elig   (prg_elig_s),
      .chr_elig   (chr_elig_s),
      .last_grant (last_grant_r),
      .gnt_valid  (gnt_valid_s),
      .gnt_sel    (gnt_sel_s)
   );

   // Next-state and next-output logic for the grant/access sequence
   always_comb begin
      state_s      = state_r;
      cur_grant_s  = cur_grant_r;
      last_grant_s = last_grant_r;
      cnt_s        = cnt_r;
      addr_s       = addr_r;
      busy_s       = busy_r;
      prg_ack_s    = 1'b0;
      chr_ack_s    = 1'b0;
      prg_data_s   = prg_data_r;
      chr_data_s   = chr_data_r;
      case (state_r)
         ST_IDLE: begin
            if (gnt_valid_s) begin
               cur_grant_s  = gnt_sel_s;
               last_grant_s = gnt_sel_s;
               cnt_s        = WAIT_LD;
               busy_s       = 1'b1;
               state_s      = ST_ACCESS;
               if (gnt_sel_s == GNT_CHR) begin
                  addr_s = chr_map_s;
               end else begin
                  addr_s = prg_map_s;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cnt_r != 4'd0) begin
               cnt_s = cnt_r - 4'd1;
            end else begin
               busy_s  = 1'b0;
               state_s = ST_IDLE;
               if (cur_grant_r == GNT_CHR) begin
                  chr_data_s = i_flash_q;
                  chr_ack_s  = 1'b1;
               end else begin
                  prg_data_s = i_flash_q;
                  prg_ack_s  = 1'b1;
               end
            end
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and output registers; reset aborts any access in flight
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cur_grant_r  <= GNT_PRG;
         last_grant_r <= GNT_PRG;
         cnt_r        <= 4'd0;
         addr_r       <= '0;
         busy_r       <= 1'b0;
         prg_ack_r    <= 1'b0;
         chr_ack_r    <= 1'b0;
         prg_data_r   <= 8'h00;
         chr_data_r   <= 8'h00;
      end else begin
         cur_grant_r  <= cur_grant_s;
         last_grant_r <= last_grant_s;
         cnt_r        <= cnt_s;
         addr_r       <= addr_s;
         busy_r       <= busy_s;
         prg_ack_r    <= prg_ack_s;
         chr_ack_r    <= chr_ack_s;
         prg_data_r   <= prg_data_s;
         chr_data_r   <= chr_data_s;
      end
   end

   assign o_flash_addr = addr_r;
   assign o_busy       = busy_r;
   assign o_prg_ack    = prg_ack_r;
   assign o_chr_ack    = chr_ack_r;
   assign o_prg_data   = prg_data_r;
   assign o_chr_data   = chr_data_r;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Directed bench for flash_read_ctrl: a default build (WAIT_CYCLES=3) and a
// zero-wait build share one clock and reset, each with its own flash model.
module tb_flash_read_ctrl;

   logic        clk = 1'b0;
   logic        rstn;

   logic        prg_req, chr_req;
   logic [19:0] prg_addr, chr_addr;
   logic        prg_ack, chr_ack, busy;
   logic [7:0]  prg_data, chr_data, flash_q;
   logic [22:0] flash_addr;

   logic        prg_req0, chr_req0;
   logic [19:0] prg_addr0, chr_addr0;
   logic        prg_ack0, chr_ack0, busy0;
   logic [7:0]  prg_data0, chr_data0, flash_q0;
   logic [22:0] flash_addr0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Flash contents: hand-placed bytes, everything else reads 8'hFF
   function automatic logic [7:0] flash_mem(input logic [22:0] a);
      case (a)
         23'h000010: return 8'hA5;
         23'h4FFFFF: return 8'h3C;
         23'h500000: return 8'hEE;
         23'h000000: return 8'h78;
         23'h000020: return 8'h5A;
         23'h400030: return 8'hC3;
         23'h000100: return 8'h11;
         23'h000101: return 8'h22;
         23'h000102: return 8'h33;
         23'h000200: return 8'h44;
         23'h000300: return 8'h9E;
         default:    return 8'hFF;
      endcase
   endfunction

   assign flash_q  = flash_mem(flash_addr);
   assign flash_q0 = flash_mem(flash_addr0);

   flash_read_ctrl #(.WAIT_CYCLES(3)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_prg_req(prg_req), .i_prg_addr(prg_addr), .o_prg_ack(prg_ack), .o_prg_data(prg_data),
      .i_chr_req(chr_req), .i_chr_addr(chr_addr), .o_chr_ack(chr_ack), .o_chr_data(chr_data),
      .o_flash_addr(flash_addr), .i_flash_q(flash_q), .o_busy(busy)
   );

   flash_read_ctrl #(.WAIT_CYCLES(0)) dut0 (
      .i_clk(clk), .i_rstn(rstn),
      .i_prg_req(prg_req0), .i_prg_addr(prg_addr0), .o_prg_ack(prg_ack0), .o_prg_data(prg_data0),
      .i_chr_req(chr_req0), .i_chr_addr(chr_addr0), .o_chr_ack(chr_ack0), .o_chr_data(chr_data0),
      .o_flash_addr(flash_addr0), .i_flash_q(flash_q0), .o_busy(busy0)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      int          ack_cyc [4];
      logic        ack_chr [4];
      logic [7:0]  step_dat [3];
      int          step_cyc [3];
      int          n_acks;
      int          stray;

      rstn = 1'b0;
      prg_req = 1'b0; chr_req = 1'b0; prg_addr = 20'h0; chr_addr = 20'h0;
      prg_req0 = 1'b0; chr_req0 = 1'b0; prg_addr0 = 20'h0; chr_addr0 = 20'h0;

      // Reset values
      #3;
      check_val("rst_addr",     32'(flash_addr), 32'h0);
      check_val("rst_busy",     32'(busy),       32'h0);
      check_val("rst_acks",     32'({prg_ack, chr_ack}), 32'h0);
      check_val("rst_data",     32'({prg_data, chr_data}), 32'h0);
      check_val("rst_dut0",     32'({busy0, prg_ack0, chr_ack0, chr_data0}), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      tick();

      // Single PRG read
      prg_req = 1'b1; prg_addr = 20'h00010;
      tick();
      check_val("prg_gnt_addr", 32'(flash_addr), 32'h000010);
      check_val("prg_gnt_busy", 32'(busy), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("prg_wait_ack", 32'({prg_ack, chr_ack}), 32'h0);
      end
      tick();
      check_val("prg_ack",      32'(prg_ack),  32'h1);
      check_val("prg_data",     32'(prg_data), 32'hA5);
      check_val("prg_no_chr",   32'(chr_ack),  32'h0);
      check_val("prg_end_busy", 32'(busy),     32'h0);
      prg_req = 1'b0;
      tick();
      check_val("prg_ack_pulse", 32'(prg_ack),  32'h0);
      check_val("prg_data_hold", 32'(prg_data), 32'hA5);

      // Single CHR read at the top of its region
      chr_req = 1'b1; chr_addr = 20'hFFFFF;
      tick();
      check_val("chr_gnt_addr", 32'(flash_addr), 32'h4FFFFF);
      for (int i = 0; i < 3; i++) tick();
      tick();
      check_val("chr_ack",      32'({chr_ack, prg_ack}), 32'h2);
      check_val("chr_data",     32'(chr_data), 32'h3C);
      chr_req = 1'b0;
      tick();

      // Both clients held: after reset first tie goes to CHR, then alternate
      reset_pulse();
      prg_req = 1'b1; prg_addr = 20'h00020;
      chr_req = 1'b1; chr_addr = 20'h00030;
      n_acks = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         check_val("ack_excl", 32'(prg_ack & chr_ack), 32'h0);
         if (prg_ack || chr_ack) begin
            if (n_acks < 4) begin
               ack_cyc[n_acks] = c;
               ack_chr[n_acks] = chr_ack;
            end
            if (chr_ack) check_val("rr_chr_data", 32'(chr_data), 32'hC3);
            else         check_val("rr_prg_data", 32'(prg_data), 32'h5A);
            n_acks++;
         end
      end
      prg_req = 1'b0; chr_req = 1'b0;
      check_val("rr_n_acks", 32'(n_acks), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < n_acks) begin
            check_val("rr_ack_cycle", 32'(ack_cyc[k]), 32'(5 * (k + 1)));
            check_val("rr_order",     32'(ack_chr[k]), 32'((k % 2) == 0 ? 1 : 0));
         end
      end
      tick();

      // PRG held continuously, offset stepped on each ack
      step_dat[0] = 8'h11; step_dat[1] = 8'h22; step_dat[2] = 8'h33;
      step_cyc[0] = 5;     step_cyc[1] = 11;    step_cyc[2] = 17;
      prg_req = 1'b1; prg_addr = 20'h00100;
      n_acks = 0;
      for (int c = 1; c <= 17; c++) begin
         tick();
         if (prg_ack) begin
            if (n_acks < 3) begin
               check_val("step_cycle", 32'(c), 32'(step_cyc[n_acks]));
               check_val("step_data",  32'(prg_data), 32'(step_dat[n_acks]));
               check_val("step_addr",  32'(flash_addr), 32'h000100 + 32'(n_acks));
            end
            n_acks++;
            prg_addr = prg_addr + 20'h1;
         end
      end
      prg_req = 1'b0;
      check_val("step_n_acks", 32'(n_acks), 32'd3);
      tick();
      tick();

      // Zero-wait build: ack on the edge after the grant
      prg_req0 = 1'b1; prg_addr0 = 20'h00000;
      tick();
      check_val("w0_gnt",  32'({busy0, prg_ack0}), 32'h2);
      check_val("w0_addr", 32'(flash_addr0), 32'h000000);
      tick();
      check_val("w0_ack",  32'({prg_ack0, chr_ack0}), 32'h2);
      check_val("w0_data", 32'(prg_data0), 32'h78);
      prg_req0 = 1'b0;
      tick();

      // Reset in the middle of an access
      prg_req = 1'b1; prg_addr = 20'h00200;
      tick();
      check_val("ra_gnt_addr", 32'(flash_addr), 32'h000200);
      tick();
      #2;
      rstn = 1'b0;
      prg_req = 1'b0;
      #1;
      check_val("ra_busy", 32'(busy), 32'h0);
      check_val("ra_addr", 32'(flash_addr), 32'h0);
      check_val("ra_data", 32'({prg_ack, prg_data}), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      stray = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (prg_ack || chr_ack || busy) stray++;
      end
      check_val("ra_no_ack", 32'(stray), 32'd0);
      prg_req = 1'b1; prg_addr = 20'h00300;
      tick();
      check_val("ra_next_addr", 32'(flash_addr), 32'h000300);
      for (int i = 0; i < 3; i++) tick();
      tick();
      check_val("ra_next_ack",  32'(prg_ack),  32'h1);
      check_val("ra_next_data", 32'(prg_data), 32'h9E);
      prg_req = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/flash_read_ctrl.md
Name: flash_read_ctrl

Overview:
Synchronous read controller between the NES core and the parallel NOR flash (23-bit address, 8-bit asynchronous data). It takes byte-read requests from two clients, PRG (CPU side) and CHR (PPU side), and arbitrates between them round-robin. It maps each request's 20-bit offset into that client's flash region, drives the flash address, waits a programmable access time, and returns the captured byte with a one-cycle ack. It sits directly upstream of the flash device / flash behavioural model.

Parameters:
WAIT_CYCLES, 3, flash access wait in clocks; data is sampled WAIT_CYCLES+1 clocks after the address is driven; legal range 0..15.
FLASH_AW, 23, flash address width.
OFFS_W, 20, client offset width (1 MiB region per client).
PRG_BASE, 23'h000000, PRG region base; must be aligned to 2^OFFS_W.
CHR_BASE, 23'h400000, CHR region base; must be aligned to 2^OFFS_W.

Ports:
i_clk  input  1  system clock; single clock domain.
i_rstn  input  1  asynchronous active-low reset.
i_prg_req  input  1  PRG read request; held high with stable i_prg_addr until o_prg_ack.
i_prg_addr  input  OFFS_W  PRG byte offset.
o_prg_ack  output  1  one-cycle pulse; o_prg_data is valid in the same cycle.
o_prg_data  output  8  PRG read data; holds until the next PRG ack.
i_chr_req  input  1  CHR read request; same rules as PRG.
i_chr_addr  input  OFFS_W  CHR byte offset.
o_chr_ack  output  1  one-cycle pulse with o_chr_data valid.
o_chr_data  output  8  CHR read data; holds until the next CHR ack.
o_flash_addr  output  FLASH_AW  registered flash address.
i_flash_q  input  8  flash data (asynchronous to address).
o_busy  output  1  high while a flash access is in flight.

Behaviour:
- Reset (async assert, sync release): state IDLE, o_flash_addr=0, both acks=0, both data=8'h00, o_busy=0, wait counter=0, last_grant=PRG (first tie goes to CHR).
- Eligibility: a port is eligible when its req=1 and its own ack register=0. This gives a mandatory one-cycle gap, so a request that is still high in its ack cycle is not re-served.
- IDLE, at a clock edge:
  - Only one port eligible: grant it.
  - Both eligible: grant the port that was NOT last_grant; update last_grant.
  - On grant: o_flash_addr <= BASE | offset; cnt <= WAIT_CYCLES; o_busy <= 1; go to ACCESS.
  - No port eligible: stay in IDLE; o_flash_addr holds.
- ACCESS:
  - cnt != 0: cnt decrements.
  - cnt == 0: the granted port's data <= i_flash_q; its ack <= 1 for exactly one cycle; o_busy <= 0; go to IDLE.
- Latency: the ack edge is WAIT_CYCLES+1 clocks after the grant edge. With WAIT_CYCLES=0, the ack comes on the edge after the grant.
- Throughput: one access per WAIT_CYCLES+2 clocks under continuous load.
- Acks are mutually exclusive and never asserted together.
- A request that changes or drops while in flight is a protocol violation. The controller does not check for it and completes the latched access.
- Address arithmetic: BASE | zero-extended offset. Upper FLASH_AW-OFFS_W bits come only from BASE, so there is no wrap into the other region.
- Reset mid-access: the access is aborted, no ack is produced, and all outputs return to reset values.

Decomposition:
- Package flash_pkg: FLASH_AW, OFFS_W, PRG_BASE, CHR_BASE constants; typedef enum {ST_IDLE, ST_ACCESS} fctl_state_t; typedef enum {GNT_PRG, GNT_CHR} fctl_grant_t.
- Optional sub-module flash_rr_arb2: 2-way round-robin arbiter (req pair + last_grant -> grant). The rest stays flat.

Test Plan:
- Single PRG read, WAIT_CYCLES=3, flash[23'h000010]=8'hA5: i_prg_addr=20'h00010 -> o_flash_addr=23'h000010 on the grant edge; o_prg_ack pulse 4 clocks later with o_prg_data=8'hA5; o_chr_ack stays 0.
- Single CHR read, flash[23'h4FFFFF]=8'h3C: i_chr_addr=20'hFFFFF -> o_flash_addr=23'h4FFFFF; o_chr_data=8'h3C; no spill into 23'h500000.
- Simultaneous PRG and CHR requests held for 4 accesses after reset -> grant order CHR, PRG, CHR, PRG; acks every 5 clocks (WAIT_CYCLES=3); no cycle with both acks high.
- PRG req held high continuously, address stepping on each ack -> exactly one ack per access, one idle gap cycle between accesses, no duplicate read.
- WAIT_CYCLES=0 build: PRG read at 20'h00000 (flash=8'h78) -> ack on the edge after the grant with data 8'h78.
- Deassert i_rstn during ACCESS (cnt=2) -> o_busy=0 and o_flash_addr=0 immediately; no ack follows; the next request after release completes normally.
